alu_sequencer: RTL and testbench

- Multi-cycle command sequencer for the Simple RISC Machine datapath.
- Accepts one 16-bit instruction at a time over a valid/ready handshake.
- Owns an 8×16 register file and the A, B, C and Z registers.
- Drives operands and opcode into the external combinational ALU, then captures its result and zero status. It is the initiator side of the ALU interface: the ALU only responds.

---
 rtl/alu_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle command sequencer for the Simple RISC Machine datapath.
// Accepts one instruction per valid/ready handshake and walks it through the
// IDLE/DECODE/LOAD_A/LOAD_B/EXEC/WRITE/STATUS sequence. It owns the register
// file and the A, B, C and Z registers, and drives the external combinational ALU.
// Optional feature macro: SHIFTER_EN applies the instruction shift field to B.
// Without it, alu_bin is B unchanged and the shift field is ignored.
module alu_sequencer #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [15:0]   cmd,
    output logic [DW-1:0] alu_ain,
    output logic [DW-1:0] alu_bin,
    output logic [1:0]    alu_op,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_status,
    output logic          done,
    output logic          err,
    output logic          z_flag,
    input  logic [2:0]    rd_addr,
    output logic [DW-1:0] rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        LOAD_A,
        LOAD_B,
        EXEC,
        WRITE,
        STATUS
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [15:0]   ir;
    logic [DW-1:0] rf [NREG];
    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic [DW-1:0] c_reg;
    logic          z_reg;

    // Instruction fields, always taken from the latched instruction register
    logic [2:0]    opc;
    logic [1:0]    op;
    logic [2:0]    rn;
    logic [2:0]    rd;
    logic [1:0]    sh;
    logic [2:0]    rm;
    logic [7:0]    imm8;

    assign opc  = ir[15:13];
    assign op   = ir[12:11];
    assign rn   = ir[10:8];
    assign rd   = ir[7:5];
    assign sh   = ir[4:3];
    assign rm   = ir[2:0];
    assign imm8 = ir[7:0];

    // Instruction classes
    logic is_movi;
    logic is_movr;
    logic is_alu;
    logic is_cmp;
    logic is_mvn;
    logic legal;

    assign is_movi = (opc == 3'b110) && (op == 2'b10);
    assign is_movr = (opc == 3'b110) && (op == 2'b00);
    assign is_alu  = (opc == 3'b101);
    assign is_cmp  = is_alu && (op == 2'b01);
    assign is_mvn  = is_alu && (op == 2'b11);
    assign legal   = is_movi || is_movr || is_alu;

    // Sign-extend the 8-bit immediate to the datapath width
    function automatic logic [DW-1:0] sext8(input logic signed [7:0] v);
        return {{(DW-8){v[7]}}, v};
    endfunction

`ifdef SHIFTER_EN
    // One-bit B-operand shifter: none, LSL, LSR (zero fill), ASR
    function automatic logic [DW-1:0] shift_b(input logic signed [DW-1:0] v,
                                              input logic [1:0]           s);
        logic [DW-1:0] r;
        case (s)
            2'b01:   r = $unsigned(v) << 1;
            2'b10:   r = $unsigned(v) >> 1;
            2'b11:   r = $unsigned(v >>> 1);
            default: r = $unsigned(v);
        endcase
        return r;
    endfunction
`else
    // Shift field is decoded but has no effect in this build
    logic unused_sh;
    assign unused_sh = ^sh;
`endif

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus handshake and completion pulses
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = DECODE;
            end
            DECODE: begin
                if (!legal) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end else if (is_movi) begin
                    state_nxt = WRITE;
                end else if (is_movr || is_mvn) begin
                    state_nxt = LOAD_B;
                end else begin
                    state_nxt = LOAD_A;
                end
            end
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = EXEC;
            EXEC:    state_nxt = is_cmp ? STATUS : WRITE;
            WRITE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            STATUS: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Instruction latch, operand loads, result/status capture and register write-back
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir    <= '0;
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
            z_reg <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) ir <= cmd;
                end
                LOAD_A: a_reg <= rf[rn];
                LOAD_B: b_reg <= rf[rm];
                EXEC: begin
                    c_reg <= alu_out;
                    if (is_alu) z_reg <= alu_status;
                end
                WRITE: begin
                    if (is_movi) rf[rn] <= sext8(imm8);
                    else         rf[rd] <= c_reg;
                end
                default: ;
            endcase
        end
    end

    // ALU drive: operands and opcode only during EXEC, zero otherwise
    always_comb begin
        alu_ain = '0;
        alu_bin = '0;
        alu_op  = 2'b00;
        if (state == EXEC) begin
`ifdef SHIFTER_EN
            alu_bin = shift_b(b_reg, sh);
`else
            alu_bin = b_reg;
`endif
            alu_ain = is_movr ? '0 : a_reg;
            alu_op  = is_movr ? 2'b00 : op;
        end
    end

    assign z_flag  = z_reg;
    assign rd_data = rf[rd_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized self-checking bench for alu_sequencer.
// Provides a combinational ALU for the DUT and compares register file, Z flag,
// completion latency and error pulses against an instruction-level model.
// Honours SHIFTER_EN the same way as the design.
module tb_alu_sequencer;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd;
    logic [15:0] alu_ain;
    logic [15:0] alu_bin;
    logic [1:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_status;
    logic        done;
    logic        err;
    logic        z_flag;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;

    int tests = 0;
    int fails = 0;

    // Instruction-level model state
    logic [15:0] mreg [8];
    logic        mz;

    alu_sequencer #(.DW(16), .NREG(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .alu_ain    (alu_ain),
        .alu_bin    (alu_bin),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_status (alu_status),
        .done       (done),
        .err        (err),
        .z_flag     (z_flag),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU
    assign alu_out = (alu_op == 2'b00) ? alu_ain + alu_bin :
                     (alu_op == 2'b01) ? alu_ain - alu_bin :
                     (alu_op == 2'b10) ? (alu_ain & alu_bin) : ~alu_bin;
    assign alu_status = (alu_out == 16'h0000);

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] opc, input logic [1:0] op,
                                       input logic [2:0] rn, input logic [2:0] rd,
                                       input logic [1:0] sh, input logic [2:0] rm);
        return {opc, op, rn, rd, sh, rm};
    endfunction

    function automatic logic [15:0] mki(input logic [2:0] rn, input logic [7:0] imm);
        return {3'b110, 2'b10, rn, imm};
    endfunction

`ifdef SHIFTER_EN
    function automatic logic [15:0] mshift(input logic [15:0] v, input logic [1:0] s);
        case (s)
            2'b01:   return v << 1;
            2'b10:   return v >> 1;
            2'b11:   return {v[15], v[15:1]};
            default: return v;
        endcase
    endfunction
`endif

    // Apply one instruction to the model; returns expected done cycle and err flag
    task automatic model_exec(input logic [15:0] c, output int exp_done, output int exp_err);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        a = mreg[c[10:8]];
        b = mreg[c[2:0]];
`ifdef SHIFTER_EN
        b = mshift(b, c[4:3]);
`endif
        exp_done = 0;
        exp_err  = 0;
        if (c[15:11] == 5'b11010) begin
            mreg[c[10:8]] = {{8{c[7]}}, c[7:0]};
            exp_done = 2;
        end else if (c[15:11] == 5'b11000) begin
            mreg[c[7:5]] = b;
            exp_done = 4;
        end else if (c[15:13] == 3'b101) begin
            case (c[12:11])
                2'b00:   r = a + b;
                2'b01:   r = a - b;
                2'b10:   r = a & b;
                default: r = ~b;
            endcase
            mz = (r == 16'h0000);
            if (c[12:11] != 2'b01) mreg[c[7:5]] = r;
            exp_done = (c[12:11] == 2'b11) ? 4 : 5;
        end else begin
            exp_err = 1;
        end
    endtask

    // Present one instruction; report the cycle (1 = DECODE) where done / err appeared
    task automatic issue(input logic [15:0] c, input bit hold, input logic [15:0] alt,
                         output int done_n, output int err_n);
        int w;
        w      = 0;
        done_n = 0;
        err_n  = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", cmd_ready, 1);
        cmd       = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) cmd = alt;
        else      cmd_valid = 1'b0;
        for (int n = 1; n <= 8 && done_n == 0 && err_n == 0; n++) begin
            @(negedge clk);
            chk("busy_ready", cmd_ready, 0);
            if (n == 1) chk("alu_idle", |{alu_ain, alu_bin, alu_op}, 0);
            if (done) done_n = n;
            if (err)  err_n = n;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic read_reg(input int i, output logic [15:0] v);
        @(negedge clk);
        rd_addr = 3'(i);
        #1;
        v = rd_data;
    endtask

    task automatic check_state(input string tag);
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            read_reg(i, v);
            chk($sformatf("%s_r%0d", tag, i), v, mreg[i]);
        end
        chk({tag, "_z"}, z_flag, mz);
    endtask

    task automatic run(input string tag, input logic [15:0] c, input bit hold,
                       input logic [15:0] alt);
        int ed;
        int ee;
        int dn;
        int en;
        model_exec(c, ed, ee);
        issue(c, hold, alt, dn, en);
        chk({tag, "_done"}, dn, ed);
        chk({tag, "_err"}, en, ee);
        check_state(tag);
    endtask

    function automatic logic [15:0] rand_cmd();
        int          k;
        logic [15:0] w;
        k = $urandom_range(0, 11);
        w = 16'($urandom);
        if (k < 3)       w[15:11] = 5'b11010;
        else if (k < 5)  w[15:11] = 5'b11000;
        else if (k < 10) w[15:13] = 3'b101;
        return w;
    endfunction

    initial begin
        logic [15:0] v;
        int          seen_done;

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 16'h0000;
        rd_addr   = 3'd0;
        for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
        mz = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_z", z_flag, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        check_state("rst_init");

        // Directed sequence
        run("movi_r0", mki(3'd0, 8'h07), 1'b0, 16'h0);
        read_reg(0, v);
        chk("plan_r0", v, 16'h0007);
        run("movi_r1", mki(3'd1, 8'hFE), 1'b0, 16'h0);
        read_reg(1, v);
        chk("plan_r1", v, 16'hFFFE);
        run("add_r2", mk(3'b101, 2'b00, 3'd1, 3'd2, 2'b00, 3'd0), 1'b0, 16'h0);
        read_reg(2, v);
        chk("plan_r2", v, 16'h0005);
        chk("plan_add_z", z_flag, 0);
        run("cmp_r0", mk(3'b101, 2'b01, 3'd0, 3'd0, 2'b00, 3'd0), 1'b0, 16'h0);
        chk("plan_cmp_z", z_flag, 1);
        run("and_r3", mk(3'b101, 2'b10, 3'd0, 3'd3, 2'b00, 3'd1), 1'b0, 16'h0);
        read_reg(3, v);
        chk("plan_r3", v, 16'h0006);
        chk("plan_and_z", z_flag, 0);
        run("mvn_r4", mk(3'b101, 2'b11, 3'd0, 3'd4, 2'b01, 3'd0), 1'b0, 16'h0);
        read_reg(4, v);
`ifdef SHIFTER_EN
        chk("plan_r4", v, 16'hFFF1);
`else
        chk("plan_r4", v, 16'hFFF8);
`endif
        run("illegal", 16'h0000, 1'b0, 16'h0);
        run("movr_asr", mk(3'b110, 2'b00, 3'd0, 3'd5, 2'b11, 3'd1), 1'b0, 16'h0);
        run("self_add", mk(3'b101, 2'b00, 3'd3, 3'd3, 2'b00, 3'd3), 1'b0, 16'h0);
        // cmd_valid held high through the busy period with a different word on cmd
        run("hold", mk(3'b101, 2'b00, 3'd1, 3'd6, 2'b00, 3'd2), 1'b1, mki(3'd7, 8'h55));

        // Randomized instructions
        for (int t = 0; t < 40; t++) begin
            run($sformatf("rnd%0d", t), rand_cmd(), 1'(t % 5 == 0), rand_cmd());
        end

        // Reset during EXEC of ADD R5,R0,R0
        seen_done = 0;
        @(negedge clk);
        cmd       = mk(3'b101, 2'b00, 3'd0, 3'd5, 2'b00, 3'd0);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        @(negedge clk);
        chk("exec_op", alu_op, 2'b00);
        chk("exec_ain", alu_ain, mreg[0]);
        chk("exec_bin", alu_bin, mreg[0]);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_done", done, 0);
        repeat (2) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
        mz = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        chk("rst_mid_nodone", seen_done, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        check_state("rst_mid");

        for (int t = 0; t < 10; t++) begin
            run($sformatf("post%0d", t), rand_cmd(), 1'b0, 16'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
